// File: rtl/smi_frame_ctrl_if.sv
// Bundle between the SMI byte stream and the framebuffer write / bank-swap controller.
// Latency: none; this is wiring only.
// Backpressure: none; the host pushes bytes and the controller has no ready signal.
//
// Ports: rx_valid/rx_data (SMI write strobe and byte) and swap_ack (display side)
// flow into the controller. fb_we/fb_addr/fb_wdata/fb_bank (framebuffer write port),
// swap_req (bank-swap request), tx_data (status byte for Pi reads) and busy flow out.
interface smi_frame_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  swap_ack;
  logic                  fb_we;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [7:0]            fb_wdata;
  logic                  fb_bank;
  logic                  swap_req;
  logic [7:0]            tx_data;
  logic                  busy;

  // Controller side.
  modport slave (
    input  rx_valid, rx_data, swap_ack,
    output fb_we, fb_addr, fb_wdata, fb_bank, swap_req, tx_data, busy
  );

  // Host / display side.
  modport master (
    output rx_valid, rx_data, swap_ack,
    input  fb_we, fb_addr, fb_wdata, fb_bank, swap_req, tx_data, busy
  );
endinterface

// File: rtl/smi_frame_ctrl.sv
// Parses SMI command bytes into framebuffer writes, bank-swap requests and status reads.
// Latency: one clk from a data byte's rx_valid to its fb_we; one data byte per clk sustained.
// Backpressure: none; bytes arriving during a pending bank swap are dropped and flagged as overrun.
//
// Ports: clk, reset (async active-low, release retimed to clk), and bus (slave modport):
//   rx_valid/rx_data  byte stream from the Pi      swap_ack  display has taken the new bank
//   fb_we/fb_addr/fb_wdata/fb_bank  framebuffer write port
//   swap_req  level request to swap banks        tx_data  status byte    busy  packet/swap active
// Packet format: 0x01 ADDR_HI ADDR_LO LEN_HI LEN_LO followed by LEN data bytes.
// ADDR_WIDTH is expected to be at most 16.
module smi_frame_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 1024
) (
  input  logic            clk,
  input  logic            reset,
  smi_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, SWAP_WAIT
  } state_t;

  localparam logic [7:0]  CMD_NOP    = 8'h00;
  localparam logic [7:0]  CMD_WRITE  = 8'h01;
  localparam logic [7:0]  CMD_SWAP   = 8'h02;
  localparam logic [7:0]  CMD_STATUS = 8'h03;
  localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT - 1);

  state_t                state, state_nxt;
  logic                  run_en;
  logic                  rx_fire, ack_fire;
  logic                  idle_counting, timeout_hit;
  logic                  status_rd, cmd_bad;
  logic [7:0]            hi_byte;
  logic [15:0]           hdr_word;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           byte_cnt;
  logic [15:0]           idle_cnt;
  logic                  err_timeout, err_cmd, overrun;
  logic                  fb_we_q, fb_bank_q;
  logic [ADDR_WIDTH-1:0] fb_addr_q;
  logic [7:0]            fb_wdata_q, tx_data_q;
  logic                  busy_o, swap_req_o;

  // Reset assertion acts at once; release is retimed through one flop, so the
  // first edge after release only arms run_en and bytes count from the second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_en <= 1'b0;
    else        run_en <= 1'b1;
  end

  assign rx_fire       = bus.rx_valid & run_en;
  assign ack_fire      = bus.swap_ack & run_en;
  assign hdr_word      = {hi_byte, bus.rx_data};
  // The watchdog only runs while a packet is open; a pending swap waits indefinitely.
  assign idle_counting = (state != IDLE) && (state != SWAP_WAIT);
  assign timeout_hit   = idle_counting && !rx_fire && (idle_cnt == IDLE_LAST);
  assign status_rd     = (state == IDLE) && rx_fire && (bus.rx_data == CMD_STATUS);
  assign cmd_bad       = (state == IDLE) && rx_fire && (bus.rx_data > CMD_STATUS);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_fire) begin
          case (bus.rx_data)
            CMD_WRITE: state_nxt = ADDR_HI;
            CMD_SWAP:  state_nxt = SWAP_WAIT;
            default:   state_nxt = IDLE;
          endcase
        end
      end
      ADDR_HI:   if (rx_fire) state_nxt = ADDR_LO;
      ADDR_LO:   if (rx_fire) state_nxt = LEN_HI;
      LEN_HI:    if (rx_fire) state_nxt = LEN_LO;
      LEN_LO:    if (rx_fire) state_nxt = (hdr_word == 16'd0) ? IDLE : DATA;
      DATA:      if (rx_fire && byte_cnt == 16'd1) state_nxt = IDLE;
      SWAP_WAIT: if (ack_fire) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  // State-decoded outputs.
  always_comb begin
    busy_o     = (state != IDLE);
    swap_req_o = (state == SWAP_WAIT);
  end

  // Datapath: header capture, write port, watchdog, sticky flags, status byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_byte     <= 8'h00;
      addr        <= '0;
      byte_cnt    <= 16'd0;
      idle_cnt    <= 16'd0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= 8'h00;
      fb_bank_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      err_timeout <= 1'b0;
      err_cmd     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      fb_we_q <= 1'b0;

      if (rx_fire)                        idle_cnt <= 16'd0;
      else if (idle_counting && !timeout_hit) idle_cnt <= idle_cnt + 16'd1;
      else                                idle_cnt <= 16'd0;

      case (state)
        ADDR_HI, LEN_HI: if (rx_fire) hi_byte <= bus.rx_data;
        // Address bits above ADDR_WIDTH are simply dropped.
        ADDR_LO: if (rx_fire) addr <= hdr_word[ADDR_WIDTH-1:0];
        LEN_LO:  if (rx_fire) byte_cnt <= hdr_word;
        DATA: begin
          if (rx_fire) begin
            fb_we_q    <= 1'b1;
            fb_addr_q  <= addr;
            fb_wdata_q <= bus.rx_data;
            addr       <= addr + 1'b1;   // wraps modulo 2^ADDR_WIDTH
            byte_cnt   <= byte_cnt - 16'd1;
          end
        end
        SWAP_WAIT: if (ack_fire) fb_bank_q <= ~fb_bank_q;
        default: ;
      endcase

      // A status read clears the flags it reports; a flag raised on that same
      // edge survives for the next read.
      err_timeout <= (err_timeout & ~status_rd) | timeout_hit;
      err_cmd     <= (err_cmd & ~status_rd) | cmd_bad;
      overrun     <= (overrun & ~status_rd) | ((state == SWAP_WAIT) && rx_fire);

      if (status_rd)
        tx_data_q <= {err_timeout, err_cmd, overrun, busy_o, 3'b000, fb_bank_q};
    end
  end

  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_wdata = fb_wdata_q;
  assign bus.fb_bank  = fb_bank_q;
  assign bus.swap_req = swap_req_o;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_o;

  // CMD_NOP is listed for readability of the command set; it needs no action.
  logic nop_seen;
  assign nop_seen = (bus.rx_data == CMD_NOP);
  logic unused_ok;
  assign unused_ok = nop_seen;

endmodule

// File: tb/tb_smi_frame_ctrl.sv
// Self-checking bench for smi_frame_ctrl: directed vector table, corner sequences, random stream.
// Latency: outputs sampled 1 ns after each rising clk edge.
// Backpressure: none; the bench drives one byte per cycle at most.
module tb_smi_frame_ctrl;
  localparam int AW = 12;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  smi_frame_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
  smi_frame_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic          v;
    logic [7:0]    d;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wd;
    logic          busy;
    logic [7:0]    tx;
  } vec_t;
  vec_t tbl[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ack;
  } stim_t;
  stim_t sq[$];

  // Reference model state: a byte-stream packet interpreter.
  logic       m_in_pkt, m_swap;
  logic [7:0] m_hdr[$];
  int         m_rem, m_idle, m_addr, m_fa;
  logic       m_eto, m_ecmd, m_ovr, m_bank, m_we;
  logic [7:0] m_wd, m_tx;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic we,
                              input logic [AW-1:0] a, input logic [7:0] wd,
                              input logic busy, input logic [7:0] tx);
    vec_t r;
    r.v = v; r.d = d; r.we = we; r.addr = a; r.wd = wd; r.busy = busy; r.tx = tx;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic we, input logic [31:0] a,
                         input logic [7:0] wd, input logic busy, input logic req,
                         input logic bank, input logic [7:0] tx);
    chk({tag, "_we"},   32'(bus.fb_we),    32'(we));
    chk({tag, "_addr"}, 32'(bus.fb_addr),  a);
    chk({tag, "_wd"},   32'(bus.fb_wdata), 32'(wd));
    chk({tag, "_busy"}, 32'(bus.busy),     32'(busy));
    chk({tag, "_req"},  32'(bus.swap_req), 32'(req));
    chk({tag, "_bank"}, 32'(bus.fb_bank),  32'(bank));
    chk({tag, "_tx"},   32'(bus.tx_data),  32'(tx));
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic ack);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.swap_ack = ack;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.swap_ack = 1'b0;
  endtask

  // Leaves the bench one edge after release, so the next cyc is accepted.
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic ack);
    m_we = 1'b0;
    if (m_swap) begin
      if (v) m_ovr = 1'b1;
      if (ack) begin m_bank = !m_bank; m_swap = 1'b0; end
    end else if (m_in_pkt) begin
      if (!v) begin
        m_idle++;
        if (m_idle == TO) begin m_in_pkt = 1'b0; m_eto = 1'b1; end
      end else begin
        m_idle = 0;
        if (m_hdr.size() < 4) begin
          m_hdr.push_back(d);
          if (m_hdr.size() == 4) begin
            m_addr = (int'(m_hdr[0]) * 256 + int'(m_hdr[1])) % (1 << AW);
            m_rem  = int'(m_hdr[2]) * 256 + int'(m_hdr[3]);
            if (m_rem == 0) m_in_pkt = 1'b0;
          end
        end else begin
          m_we   = 1'b1;
          m_fa   = m_addr;
          m_wd   = d;
          m_addr = (m_addr + 1) % (1 << AW);
          m_rem--;
          if (m_rem == 0) m_in_pkt = 1'b0;
        end
      end
    end else if (v) begin
      case (d)
        8'h00: ;
        8'h01: begin m_in_pkt = 1'b1; m_hdr.delete(); m_idle = 0; end
        8'h02: m_swap = 1'b1;
        8'h03: begin
          m_tx  = {m_eto, m_ecmd, m_ovr, 1'b0, 3'b000, m_bank};
          m_eto = 1'b0; m_ecmd = 1'b0; m_ovr = 1'b0;
        end
        default: m_ecmd = 1'b1;
      endcase
    end
  endtask

  task automatic push(input logic v, input logic [7:0] d, input logic ack);
    stim_t s;
    s.v = v; s.d = d; s.ack = ack;
    sq.push_back(s);
  endtask

  task automatic push_gap(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 8'h00, ($urandom_range(0, 15) == 0));
  endtask

  task automatic push_byte(input logic [7:0] d);
    push(1'b1, d, ($urandom_range(0, 15) == 0));
    if ($urandom_range(0, 19) == 0) push_gap(TO - 2 + $urandom_range(0, 3));
    else                            push_gap($urandom_range(0, 2));
  endtask

  initial begin
    logic any_we;
    int   len;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.swap_ack = 1'b0;

    // Directed vectors: back-to-back bytes, outputs after each edge.
    tbl.push_back(mk(1, 8'h01, 0, 12'h000, 8'h00, 1, 8'h00));
    tbl.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 8'h00));
    tbl.push_back(mk(1, 8'h10, 0, 12'h000, 8'h00, 1, 8'h00));
    tbl.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 8'h00));
    tbl.push_back(mk(1, 8'h03, 0, 12'h000, 8'h00, 1, 8'h00));
    tbl.push_back(mk(1, 8'hAA, 1, 12'h010, 8'hAA, 1, 8'h00));
    tbl.push_back(mk(1, 8'hBB, 1, 12'h011, 8'hBB, 1, 8'h00));
    tbl.push_back(mk(1, 8'hCC, 1, 12'h012, 8'hCC, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 12'h012, 8'hCC, 0, 8'h00));
    tbl.push_back(mk(1, 8'h01, 0, 12'h012, 8'hCC, 1, 8'h00));
    tbl.push_back(mk(1, 8'h0F, 0, 12'h012, 8'hCC, 1, 8'h00));
    tbl.push_back(mk(1, 8'hFF, 0, 12'h012, 8'hCC, 1, 8'h00));
    tbl.push_back(mk(1, 8'h00, 0, 12'h012, 8'hCC, 1, 8'h00));
    tbl.push_back(mk(1, 8'h02, 0, 12'h012, 8'hCC, 1, 8'h00));
    tbl.push_back(mk(1, 8'h11, 1, 12'hFFF, 8'h11, 1, 8'h00));
    tbl.push_back(mk(1, 8'h22, 1, 12'h000, 8'h22, 0, 8'h00));
    tbl.push_back(mk(1, 8'h7F, 0, 12'h000, 8'h22, 0, 8'h00));
    tbl.push_back(mk(1, 8'h03, 0, 12'h000, 8'h22, 0, 8'h40));
    tbl.push_back(mk(1, 8'h01, 0, 12'h000, 8'h22, 1, 8'h40));
    tbl.push_back(mk(1, 8'h00, 0, 12'h000, 8'h22, 1, 8'h40));
    tbl.push_back(mk(1, 8'h00, 0, 12'h000, 8'h22, 1, 8'h40));
    tbl.push_back(mk(1, 8'h00, 0, 12'h000, 8'h22, 1, 8'h40));
    tbl.push_back(mk(1, 8'h00, 0, 12'h000, 8'h22, 0, 8'h40));
    tbl.push_back(mk(0, 8'h00, 0, 12'h000, 8'h22, 0, 8'h40));

    // Reset values, applied asynchronously and held across an edge.
    #2 reset = 1'b0;
    #1 chk_all("rst_async", 0, 0, 8'h00, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
    chk_all("rst_hold", 0, 0, 8'h00, 0, 0, 0, 8'h00);

    // Release timing: first edge ignores bytes, second accepts.
    reset = 1'b1;
    cyc(1, 8'h01, 0); chk("rel_edge1_busy", 32'(bus.busy), 0);
    cyc(1, 8'h7F, 0); chk("rel_edge2_busy", 32'(bus.busy), 0);
    cyc(1, 8'h03, 0); chk("rel_status", 32'(bus.tx_data), 32'h40);

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, 1'b0);
      chk_all($sformatf("tbl%0d", i), tbl[i].we, 32'(tbl[i].addr), tbl[i].wd,
              tbl[i].busy, 1'b0, 1'b0, tbl[i].tx);
    end

    // Swap with ack after five cycles and a stray byte during the wait.
    cyc(1, 8'h02, 0);
    chk("swp_req0", 32'(bus.swap_req), 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(i == 2, 8'h55, 0);
      chk($sformatf("swp_req%0d", i), 32'(bus.swap_req), 1);
      chk($sformatf("swp_bank%0d", i), 32'(bus.fb_bank), 0);
    end
    cyc(0, 8'h00, 1);
    chk("swp_req_drop", 32'(bus.swap_req), 0);
    chk("swp_bank1", 32'(bus.fb_bank), 1);
    chk("swp_busy", 32'(bus.busy), 0);
    cyc(1, 8'h03, 0); chk("swp_status", 32'(bus.tx_data), 32'h21);
    cyc(1, 8'h03, 0); chk("swp_status2", 32'(bus.tx_data), 32'h01);

    // Reset in the middle of a packet, two of four bytes written.
    cyc(1, 8'h01, 0); cyc(1, 8'h00, 0); cyc(1, 8'h20, 0); cyc(1, 8'h00, 0);
    cyc(1, 8'h04, 0); cyc(1, 8'hA1, 0); cyc(1, 8'hA2, 0);
    chk("mid_pre_we", 32'(bus.fb_we), 1);
    chk("mid_pre_addr", 32'(bus.fb_addr), 32'h021);
    reset = 1'b0;
    #1 chk_all("mid_rst", 0, 0, 8'h00, 0, 0, 0, 8'h00);
    cyc(1, 8'hA3, 0); chk("mid_rst_we3", 32'(bus.fb_we), 0);
    cyc(1, 8'hA4, 0); chk("mid_rst_we4", 32'(bus.fb_we), 0);
    reset = 1'b1;
    cyc(0, 8'h00, 0);
    cyc(1, 8'h03, 0); chk("mid_status", 32'(bus.tx_data), 32'h00);

    // Reset while a swap is pending, with overrun flagged.
    cyc(1, 8'h02, 0); cyc(0, 8'h00, 1);
    chk("sw_rst_bank_pre", 32'(bus.fb_bank), 1);
    cyc(1, 8'h02, 0); cyc(1, 8'h66, 0);
    chk("sw_rst_req_pre", 32'(bus.swap_req), 1);
    reset = 1'b0;
    #1 chk_all("sw_rst", 0, 0, 8'h00, 0, 0, 0, 8'h00);
    cyc(0, 8'h00, 1); chk("sw_rst_ack_ign", 32'(bus.fb_bank), 0);
    reset = 1'b1;
    cyc(0, 8'h00, 0);
    cyc(1, 8'h03, 0); chk("sw_rst_status", 32'(bus.tx_data), 32'h00);

    // Watchdog: header then silence.
    cyc(1, 8'h01, 0); cyc(1, 8'h00, 0); cyc(1, 8'h00, 0); cyc(1, 8'h00, 0); cyc(1, 8'h05, 0);
    any_we = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      cyc(0, 8'h00, 0);
      if (bus.fb_we) any_we = 1'b1;
      if (i == TO - 1) chk("to_busy_before", 32'(bus.busy), 1);
      if (i == TO)     chk("to_busy_after", 32'(bus.busy), 0);
    end
    chk("to_no_we", 32'(any_we), 0);
    cyc(1, 8'h03, 0); chk("to_status", 32'(bus.tx_data), 32'h80);
    cyc(1, 8'h03, 0); chk("to_status_clr", 32'(bus.tx_data), 32'h00);

    // Byte and ack on the same edge: ack wins, byte counts as overrun.
    cyc(1, 8'h02, 0);
    cyc(1, 8'h44, 1);
    chk("col_req", 32'(bus.swap_req), 0);
    chk("col_bank", 32'(bus.fb_bank), 1);
    chk("col_busy", 32'(bus.busy), 0);
    cyc(1, 8'h03, 0); chk("col_status", 32'(bus.tx_data), 32'h21);

    // Random stream against the packet-interpreter model.
    while (sq.size() < 2500) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          len = $urandom_range(0, 6);
          push_byte(8'h01);
          push_byte(8'($urandom_range(0, 255)));
          push_byte(8'($urandom_range(0, 255)));
          push_byte(8'h00);
          push_byte(8'(len));
          for (int k = 0; k < len; k++) push_byte(8'($urandom_range(0, 255)));
        end
        5, 6: begin
          push(1'b1, 8'h02, 1'b0);
          for (int k = $urandom_range(0, 6); k > 0; k--)
            push(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1'b0);
          push(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1'b1);
        end
        7: push_byte(8'h03);
        8: push_byte(8'($urandom_range(0, 255)));
        default: push_gap($urandom_range(0, 3));
      endcase
    end
    do_reset();
    m_in_pkt = 0; m_swap = 0; m_hdr.delete(); m_rem = 0; m_idle = 0; m_addr = 0; m_fa = 0;
    m_eto = 0; m_ecmd = 0; m_ovr = 0; m_bank = 0; m_we = 0; m_wd = 8'h00; m_tx = 8'h00;
    foreach (sq[i]) begin
      cyc(sq[i].v, sq[i].d, sq[i].ack);
      model_step(sq[i].v, sq[i].d, sq[i].ack);
      chk_all("rnd", m_we, 32'(m_fa), m_wd, m_in_pkt | m_swap, m_swap, m_bank, m_tx);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/smi_frame_ctrl.md
SMI_FRAME_CTRL -- requirements
Module: smi_frame_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: framebuffer word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 1024: idle-cycle limit inside a packet, 1..65535.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_valid  input  1  one-cycle pulse: byte written by Pi (SMI write strobe).
REQ-006 rx_data  input  8  byte from SMI, valid with rx_valid.
REQ-007 swap_ack  input  1  display side has taken the new bank.
REQ-008 fb_we  output  1  framebuffer write enable, one cycle per data byte.
REQ-009 fb_addr  output  ADDR_WIDTH  framebuffer write address.
REQ-010 fb_wdata  output  8  framebuffer write data.
REQ-011 fb_bank  output  1  bank currently being written.
REQ-012 swap_req  output  1  level request to swap banks.
REQ-013 tx_data  output  8  status byte driven to SMI for Pi reads.
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 States SHALL be IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, SWAP_WAIT; bytes are consumed only on rx_valid.
REQ-016 IDLE on 0x01 -> ADDR_HI; on 0x02 -> SWAP_WAIT with swap_req=1 next cycle; on 0x03 -> latch status (REQ-024) into tx_data, stay IDLE; on 0x00 -> ignore; any other value -> set err_cmd, stay IDLE.
REQ-017 ADDR_HI/ADDR_LO SHALL load start address big-endian; bits above ADDR_WIDTH are discarded.
REQ-018 LEN_HI/LEN_LO SHALL load 16-bit byte count; count 0 -> IDLE after LEN_LO, no writes.
REQ-019 DATA: each rx_valid SHALL produce fb_we=1 the next cycle with fb_wdata=rx_data and fb_addr=current address; address then increments, count decrements; count reaching 0 -> IDLE in the same cycle as the last fb_we.
REQ-020 fb_addr SHALL wrap modulo 2^ADDR_WIDTH; wrap is not an error.
REQ-021 SWAP_WAIT: swap_req held high until swap_ack sampled high; then fb_bank toggles, swap_req drops, -> IDLE, all on the same edge.
REQ-022 rx_valid in SWAP_WAIT SHALL be dropped and set sticky flag overrun; rx_valid and swap_ack in the same cycle: ack wins, byte dropped, overrun set.
REQ-023 Idle counter SHALL reset on every rx_valid and count in any state except IDLE and SWAP_WAIT; reaching TIMEOUT -> abort to IDLE, set err_timeout, no further fb_we.
REQ-024 Status byte = {err_timeout, err_cmd, overrun, busy, 3'b000, fb_bank}; sticky flags cleared on the cycle tx_data latches them; a flag set in that same cycle stays set.
REQ-025 Throughput SHALL be one data byte per clk with rx_valid every cycle; no back-pressure exists.

Reset
REQ-026 Asserting reset (low) SHALL immediately force IDLE, fb_we=0, fb_addr=0, fb_wdata=0, fb_bank=0, swap_req=0, tx_data=0, busy=0, all sticky flags 0, counters 0, including mid-packet and mid-swap.
REQ-027 Release SHALL be synchronised to clk; first rx_valid accepted on the second posedge after deassertion.

Verification
REQ-028 Bytes 01 00 10 00 03 AA BB CC -> fb_we at addresses 0x010,0x011,0x012 with AA,BB,CC; busy drops with last write.
REQ-029 Bytes 01 0F FF 00 02 11 22 (ADDR_WIDTH=12) -> writes 0xFFF=11, 0x000=22.
REQ-030 Byte 02, swap_ack after 5 cycles, rx_valid during wait -> swap_req high 5 cycles, fb_bank 0->1, then 03 -> tx_data=0x21.
REQ-031 Bytes 01 00 00 00 05 then silence TIMEOUT cycles -> IDLE, no fb_we; then 03 -> tx_data=0x80, following 03 -> 0x00.
REQ-032 Byte 7F then 03 -> tx_data=0x40; 01 00 00 00 00 -> no fb_we, IDLE.
REQ-033 reset low during DATA after 2 of 4 bytes and during SWAP_WAIT -> all outputs at REQ-026 values immediately, remaining bytes do not write.
